// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns an opcode select plus fields into a 32-bit word and writes it to instruction memory.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
module instr_encoder #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     restart,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               opsel,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [31:0]              imm,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_ready,
   output logic [ADDRESS_WIDTH-1:0] word_count,
   output logic                     err
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STOR = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t      state;
   logic [31:0] enc_word;
   logic        enc_legal;

   // imm bits above the JAL field only matter when range checking is built in
   logic unused_imm_hi;
   assign unused_imm_hi = &{1'b0, imm[31:21]};

   assign in_ready = !rst && (state == IDLE) && !restart;

`ifdef ENC_IMM_CHECK_EN
   logic signed [31:0] simm;
   logic i_ok, sh_ok, b_ok, j_ok;

   assign simm  = $signed(imm);
   assign i_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
   assign sh_ok = (simm >= 32'sd0) && (simm <= 32'sd31);
   assign b_ok  = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
   assign j_ok  = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
`endif

   // Combinational encoder; unused fields simply never reach the word
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b1;
      case (opsel)
         4'd0: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
         4'd1: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
         4'd2: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_IMM};
         4'd3: enc_word = {7'b0000000, imm[4:0], rs1, 3'b001, rd, OP_IMM};
         4'd4: enc_word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
         4'd5: enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STOR};
         4'd6: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
         4'd7: enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OP_BR};
         4'd8: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         4'd9: enc_word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
         default: enc_legal = 1'b0;
      endcase
`ifdef ENC_IMM_CHECK_EN
      case (opsel)
         4'd2, 4'd4, 4'd5, 4'd9: enc_legal = enc_legal && i_ok;
         4'd3:                   enc_legal = enc_legal && sh_ok;
         4'd6, 4'd7:             enc_legal = enc_legal && b_ok;
         4'd8:                   enc_legal = enc_legal && j_ok;
         default:                enc_legal = enc_legal;
      endcase
`endif
   end

   // Handshake FSM with registered memory-side outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         word_count <= '0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (restart) begin
                  mem_addr   <= BASE_ADDR;
                  word_count <= '0;
               end else if (in_valid) begin
                  if (enc_legal) begin
                     mem_wdata <= enc_word;
                     mem_we    <= 1'b1;
                     state     <= EMIT;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            EMIT: begin
               // restart is deliberately ignored here so the pending word lands
               if (mem_ready) begin
                  mem_we     <= 1'b0;
                  mem_addr   <= mem_addr + ADDRESS_WIDTH'(4);
                  word_count <= word_count + ADDRESS_WIDTH'(1);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized requests against an arithmetic reference model.
module tb_instr_encoder;

   localparam int unsigned AW = 8;
   localparam logic [AW-1:0] BASE = 8'hF0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          restart = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    opsel = '0;
   logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
   logic [31:0]   imm = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          mem_ready = 1'b0;
   logic [AW-1:0] word_count;
   logic          err;

   int total = 0;
   int bad = 0;
   logic [AW-1:0] exp_addr = BASE;
   logic [AW-1:0] exp_cnt = '0;
   logic [31:0]   last_w;
   logic [AW-1:0] last_a;

   instr_encoder #(.ADDRESS_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
      .opsel(opsel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .word_count(word_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: builds the word by placing each field at its bit weight with plain arithmetic
   function automatic logic [31:0] ref_word(input int op, input int unsigned d, input int unsigned s1,
                                            input int unsigned s2, input int unsigned u);
      int unsigned w;
      case (op)
         0: w = 51 + (d << 7) + (s1 << 15) + (s2 << 20);
         1: w = 51 + (d << 7) + (s1 << 15) + (s2 << 20) + (32 << 25);
         2: w = 19 + (d << 7) + (s1 << 15) + ((u % 4096) << 20);
         3: w = 19 + (d << 7) + (1 << 12) + (s1 << 15) + ((u % 32) << 20);
         4: w = 3 + (d << 7) + (2 << 12) + (s1 << 15) + ((u % 4096) << 20);
         5: w = 35 + ((u % 32) << 7) + (2 << 12) + (s1 << 15) + (s2 << 20) + (((u / 32) % 128) << 25);
         6, 7: w = 99 + (((u / 2048) % 2) << 7) + (((u / 2) % 16) << 8) + ((op - 6) << 12)
                   + (s1 << 15) + (s2 << 20) + (((u / 32) % 64) << 25) + (((u / 4096) % 2) << 31);
         8: w = 111 + (d << 7) + (((u / 4096) % 256) << 12) + (((u / 2048) % 2) << 20)
                + (((u / 2) % 1024) << 21) + (((u / 1048576) % 2) << 31);
         9: w = 103 + (d << 7) + (s1 << 15) + ((u % 4096) << 20);
         default: w = 0;
      endcase
      return w;
   endfunction

   function automatic bit ref_legal(input int op, input int v);
      if (op > 9) return 1'b0;
`ifdef ENC_IMM_CHECK_EN
      case (op)
         2, 4, 5, 9: return (v >= -2048) && (v <= 2047);
         3:          return (v >= 0) && (v <= 31);
         6, 7:       return (v % 2 == 0) && (v >= -4096) && (v <= 4094);
         8:          return (v % 2 == 0) && (v >= -1048576) && (v <= 1048574);
         default:    return 1'b1;
      endcase
`else
      return 1'b1;
`endif
   endfunction

   // One request; dly cycles of mem_ready=0 in EMIT, optional restart held during those cycles
   task automatic send(input int op, input int d, input int s1, input int s2, input int v,
                       input int dly, input bit rs_emit);
      logic [31:0] ew;
      bit lg;
      ew = ref_word(op, d, s1, s2, v);
      lg = ref_legal(op, v);
      @(negedge clk);
      check("ready_idle", in_ready, 1'b1);
      in_valid = 1'b1; opsel = 4'(op); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = v;
      mem_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      if (lg) begin
         last_w = mem_wdata; last_a = mem_addr;
         check("we_first", mem_we, 1'b1);
         check("wdata", mem_wdata, ew);
         check("addr", mem_addr, exp_addr);
         check("err_legal", err, 1'b0);
         for (int i = 0; i < dly; i++) begin
            if (rs_emit) restart = 1'b1;
            @(negedge clk);
            check("we_hold", mem_we, 1'b1);
            check("wdata_hold", mem_wdata, ew);
            check("addr_hold", mem_addr, exp_addr);
            check("ready_emit", in_ready, 1'b0);
         end
         restart = 1'b0;
         mem_ready = 1'b1;
         @(negedge clk);
         mem_ready = 1'b0;
         exp_addr = exp_addr + AW'(4);
         exp_cnt = exp_cnt + AW'(1);
         check("we_done", mem_we, 1'b0);
         check("addr_next", mem_addr, exp_addr);
         check("count", word_count, exp_cnt);
      end else begin
         check("err_pulse", err, 1'b1);
         check("we_illegal", mem_we, 1'b0);
         @(negedge clk);
         check("err_clear", err, 1'b0);
         check("we_illegal2", mem_we, 1'b0);
         check("addr_illegal", mem_addr, exp_addr);
         check("count_illegal", word_count, exp_cnt);
      end
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1; in_valid = 1'b1; opsel = 4'd0;
      #1 check("ready_restart", in_ready, 1'b0);
      @(negedge clk);
      restart = 1'b0; in_valid = 1'b0;
      exp_addr = BASE; exp_cnt = '0;
      check("restart_we", mem_we, 1'b0);
      check("restart_err", err, 1'b0);
      check("restart_addr", mem_addr, exp_addr);
      check("restart_cnt", word_count, exp_cnt);
   endtask

   initial begin
      int op, v, sel;
      // reset state
      #12;
      check("rst_we", mem_we, 1'b0);
      check("rst_addr", mem_addr, BASE);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_cnt", word_count, 8'h0);
      check("rst_err", err, 1'b0);
      check("rst_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      send(2, 1, 0, 0, 5, 0, 1'b0);
      check("addi_vec", last_w, 32'h00500093);
      check("addi_addr", last_a, BASE);
      check("addi_cnt", word_count, 8'd1);
      send(5, 0, 3, 2, 8, 0, 1'b0);
      check("sw_vec", last_w, 32'h0021A423);
      check("sw_addr", last_a, BASE + AW'(4));
      send(7, 0, 1, 0, -4, 1, 1'b0);
      check("bne_vec", last_w, 32'hFE009EE3);
      send(8, 1, 0, 0, 8, 3, 1'b0);
      check("jal_vec", last_w, 32'h008000EF);
      send(12, 3, 3, 3, 0, 0, 1'b0);
      send(1, 3, 1, 2, 0, 2, 1'b1);
      check("sub_vec", last_w, 32'h402081B3);
      do_restart();
      send(0, 4, 5, 6, 0, 0, 1'b0);
      check("post_restart_addr", last_a, BASE);
      send(2, 1, 0, 0, 4096, 0, 1'b0);
      send(6, 2, 3, 4, 4094, 0, 1'b0);
      send(8, 7, 0, 0, -1048576, 0, 1'b0);

      // randomized requests; 8-bit address exercises wraparound
      for (int n = 0; n < 60; n++) begin
         op = int'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: v = int'($urandom_range(0, 80)) - 40;
            1: v = 2 * (int'($urandom_range(0, 8000)) - 4000);
            2: v = int'($urandom);
            default: v = int'($urandom_range(0, 40)) - 8;
         endcase
         send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), v, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 9) == 0) do_restart();
      end

      // asynchronous reset while a write is pending
      @(negedge clk);
      in_valid = 1'b1; opsel = 4'd2; rd = 5'd1; imm = 32'd1;
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_we", mem_we, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_we", mem_we, 1'b0);
      check("async_rst_addr", mem_addr, BASE);
      check("async_rst_cnt", word_count, 8'h0);
      check("async_rst_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      exp_addr = BASE; exp_cnt = '0;
      send(3, 9, 10, 0, 17, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 ADDRESS_WIDTH, default 32: width of the instruction-memory write address and word counter.
REQ-002 BASE_ADDR, default 0: first instruction-memory address written after reset or restart.
REQ-003 clk  in  1  single clock; every register updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 restart  in  1  reloads the write address and clears the word count.
REQ-006 in_valid  in  1  an instruction request is presented.
REQ-007 in_ready  out  1  the block can accept a request.
REQ-008 opsel  in  4  instruction select: 0 ADD, 1 SUB, 2 ADDI, 3 SLLI, 4 LW, 5 SW, 6 BEQ, 7 BNE, 8 JAL, 9 JALR; 10-15 illegal.
REQ-009 rd, rs1, rs2  in  5 each  register fields.
REQ-010 imm  in  32  signed immediate as a byte offset; for SLLI it is the shift amount.
REQ-011 mem_we  out  1  write strobe for the instruction-memory word.
REQ-012 mem_addr  out  ADDRESS_WIDTH  word write address, byte-addressed.
REQ-013 mem_wdata  out  32  encoded instruction word.
REQ-014 mem_ready  in  1  instruction memory accepts the write this cycle.
REQ-015 word_count  out  ADDRESS_WIDTH  number of words written since the last reset or restart.
REQ-016 err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-017 The FSM SHALL have two states, IDLE and EMIT; in_ready SHALL be 1 only in IDLE with restart low.
REQ-018 In IDLE, in_valid&&in_ready on a legal request SHALL register the encoded word and enter EMIT on the next edge; latency from acceptance to mem_we is 1 cycle.
REQ-019 In EMIT, mem_we SHALL be 1, and mem_addr and mem_wdata SHALL stay stable until mem_ready is sampled 1.
REQ-020 In EMIT with mem_ready=1, the block SHALL add 4 to mem_addr, add 1 to word_count and return to IDLE, giving at most one word per 2 cycles.
REQ-021 mem_addr and word_count SHALL wrap modulo 2^ADDRESS_WIDTH with no flag.
REQ-022 R-type words (ADD, SUB) SHALL be funct7|rs2|rs1|000|rd|0110011, with funct7 = 0000000 for ADD and 0100000 for SUB.
REQ-023 I-type words SHALL be imm[11:0]|rs1|funct3|rd|opcode: ADDI 000/0010011, LW 010/0000011, JALR 000/1100111.
REQ-024 SLLI SHALL be 0000000|imm[4:0]|rs1|001|rd|0010011.
REQ-025 SW SHALL be imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
REQ-026 BEQ/BNE SHALL be imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011, with funct3 000 for BEQ and 001 for BNE.
REQ-027 JAL SHALL be imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
REQ-028 Fields not used by an instruction SHALL be ignored.
REQ-029 An illegal opsel SHALL be accepted (in_ready handshake completes), produce no write, pulse err for one cycle, and leave the FSM in IDLE.
REQ-030 restart=1 in IDLE SHALL set mem_addr to BASE_ADDR and word_count to 0 on the next edge.
REQ-031 restart SHALL override a simultaneous in_valid, which is not accepted.
REQ-032 restart=1 in EMIT SHALL be ignored; the pending write completes.

Reset
REQ-033 While rst is high, the block SHALL hold: state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, err=0; in_ready SHALL be 0.
REQ-034 An rst assertion during EMIT SHALL drop the pending write immediately and asynchronously.

Configuration
REQ-035 With ENC_IMM_CHECK_EN defined, the following requests SHALL be rejected as in REQ-029:
- I-type or S-type imm outside -2048..2047.
- SLLI imm outside 0..31.
- Branch imm that is odd or outside -4096..4094.
- JAL imm that is odd or outside -1048576..1048574.
REQ-036 Without ENC_IMM_CHECK_EN, out-of-range immediates SHALL be silently truncated to their encoded bits and never raise err.

Verification
REQ-037 ADDI rd=1 rs1=0 imm=5, mem_ready=1 -> mem_wdata=0x00500093 at mem_addr=BASE_ADDR; word_count=1.
REQ-038 BNE rs1=1 rs2=0 imm=-4 -> 0xFE009EE3; SW rs2=2 rs1=3 imm=8 -> 0x0021A423 at BASE_ADDR+4.
REQ-039 JAL rd=1 imm=8, mem_ready held 0 for 3 cycles -> mem_we and 0x008000EF stable for 4 cycles; in_ready=0 throughout.
REQ-040 SUB rd=3 rs1=1 rs2=2, then restart -> 0x402081B3 written; next word goes to BASE_ADDR with word_count=0.
REQ-041 opsel=12 -> err pulse, no mem_we; with ENC_IMM_CHECK_EN, ADDI imm=4096 -> err, no write; rst asserted during EMIT -> mem_we falls immediately.
